// File: rtl/wb_downsizer_pkg.sv
// -----------------------------------------------------------------------------
// wb_downsizer_pkg
//   Shared constants and types for the 128-to-32 bit Wishbone downsizer.
//   Bus widths, derived lane geometry and the controller state encoding
//   live here so the interface, the lane search and the top agree on them.
// -----------------------------------------------------------------------------
package wb_downsizer_pkg;

  localparam int ADDR_WIDTH       = 32;
  localparam int WIDE_WIDTH       = 128;
  localparam int NARROW_WIDTH     = 32;
  localparam int ADDR_GRANULARITY = 8;

  // Derived lane geometry.
  localparam int LANES    = WIDE_WIDTH / NARROW_WIDTH;        // narrow lanes per line
  localparam int LSEL     = NARROW_WIDTH / ADDR_GRANULARITY;  // select bits per lane
  localparam int WIDE_SEL = WIDE_WIDTH / ADDR_GRANULARITY;    // select bits per line
  localparam int LANE_W   = $clog2(LANES);
  localparam int LSEL_W   = $clog2(LSEL);
  localparam int LINE_W   = LANE_W + LSEL_W;                  // line-offset address bits

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GAP,
    RESP,
    FAIL
  } state_t;

endpackage

// File: rtl/wb_downsizer_if.sv
// -----------------------------------------------------------------------------
// wb_downsizer_if
//   One Wishbone classic bus segment. Instantiated once per side: the wide
//   (128-bit) request side and the narrow (32-bit) peripheral side.
//   Ports:
//     master modport : drives adr, dat_w, we, sel, stb, cyc;
//                      receives dat_r, ack, err, rty
//     slave modport  : the mirror image
// -----------------------------------------------------------------------------
interface wb_downsizer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
);

  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] dat_w;   // master -> slave
  logic [DATA_WIDTH-1:0] dat_r;   // slave -> master
  logic                  we;
  logic [SEL_WIDTH-1:0]  sel;
  logic                  stb;
  logic                  cyc;
  logic                  ack;
  logic                  err;
  logic                  rty;

  modport master (
    output adr, dat_w, we, sel, stb, cyc,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  adr, dat_w, we, sel, stb, cyc,
    output dat_r, ack, err, rty
  );

endinterface

// File: rtl/wb_downsizer_lane_next_sel.sv
// -----------------------------------------------------------------------------
// wb_downsizer_lane_next_sel
//   Combinational priority encoder over the wide byte-select vector.
//   Returns the lowest lane index >= start_i whose select slice is nonzero.
//   start_i is one bit wider than a lane index so "one past the last lane"
//   is representable and simply yields found_o = 0 (no wrap-around).
//   Ports:
//     sel_i   : wide byte selects
//     start_i : first lane eligible for selection
//     lane_o  : chosen lane (0 when nothing found)
//     found_o : a lane was found
// -----------------------------------------------------------------------------
module wb_downsizer_lane_next_sel
  import wb_downsizer_pkg::*;
(
  input  logic [WIDE_SEL-1:0] sel_i,
  input  logic [LANE_W:0]     start_i,
  output logic [LANE_W-1:0]   lane_o,
  output logic                found_o
);

  always_comb begin
    // NOTE: every output gets a default before the search so no latch is inferred.
    lane_o  = '0;
    found_o = 1'b0;
    // Walk downward so the lowest qualifying lane is the last one written.
    for (int i = LANES - 1; i >= 0; i--) begin
      if ((i >= int'(start_i)) && (|sel_i[i*LSEL +: LSEL])) begin
        lane_o  = LANE_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_downsizer.sv
// -----------------------------------------------------------------------------
// wb_downsizer
//   Wishbone classic width converter: accepts one 128-bit cycle on the wide
//   side, issues one 32-bit cycle per lane with any select bit set, then
//   returns a single wide ack (or err) carrying the assembled read data.
//   Ports:
//     clk : clock, all logic on posedge
//     rst : synchronous active-high reset
//     wbs : wide bus, this block is the slave (adr, dat_w, we, sel, stb, cyc in;
//           dat_r, ack, err out; rty tied low)
//     wbm : narrow bus, this block is the master (adr, dat_w, we, sel, stb, cyc
//           out; dat_r, ack, err, rty in)
// -----------------------------------------------------------------------------
module wb_downsizer
  import wb_downsizer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  wb_downsizer_if.slave   wbs,
  wb_downsizer_if.master  wbm
);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [WIDE_WIDTH-1:0] dat_q;
  logic [WIDE_WIDTH-1:0] acc_q;     // read accumulator, unselected lanes stay 0
  logic [WIDE_SEL-1:0]   sel_q;
  logic                  we_q;
  logic [LANE_W-1:0]     lane_q;
  logic                  stb_q;
  logic                  ack_q;
  logic                  err_q;

  // One lane search serves both purposes: in IDLE it finds the first lane of
  // the incoming request, otherwise the next lane after the current one.
  logic [WIDE_SEL-1:0] srch_sel_d;
  logic [LANE_W:0]     srch_start_d;
  logic [LANE_W-1:0]   srch_lane_d;
  logic                srch_found_d;

  always_comb begin
    if (state_q == IDLE) begin
      srch_sel_d   = wbs.sel;
      srch_start_d = '0;
    end else begin
      srch_sel_d   = sel_q;
      srch_start_d = {1'b0, lane_q} + (LANE_W+1)'(1);
    end
  end

  wb_downsizer_lane_next_sel u_lane_next_sel (
    .sel_i   (srch_sel_d),
    .start_i (srch_start_d),
    .lane_o  (srch_lane_d),
    .found_o (srch_found_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      acc_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      lane_q  <= '0;
      stb_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        IDLE: begin
          if (wbs.cyc && wbs.stb) begin
            adr_q  <= wbs.adr;
            dat_q  <= wbs.dat_w;
            sel_q  <= wbs.sel;
            we_q   <= wbs.we;
            acc_q  <= '0;
            lane_q <= srch_lane_d;
            if (srch_found_d) begin
              stb_q   <= 1'b1;
              state_q <= ISSUE;
            end else begin
              ack_q   <= 1'b1;
              state_q <= RESP;
            end
          end
        end

        ISSUE: begin
          if (!wbs.cyc) begin
            // Abort: abandon the narrow cycle, ignore any termination seen now.
            stb_q   <= 1'b0;
            state_q <= IDLE;
          end else if (wbm.err) begin
            stb_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= FAIL;
          end else if (wbm.ack) begin
            acc_q[int'(lane_q)*NARROW_WIDTH +: NARROW_WIDTH] <= wbm.dat_r;
            if (srch_found_d) begin
              // Keep stb high so the next lane goes out back-to-back.
              lane_q <= srch_lane_d;
            end else begin
              stb_q   <= 1'b0;
              ack_q   <= 1'b1;
              state_q <= RESP;
            end
          end else if (wbm.rty) begin
            stb_q   <= 1'b0;
            state_q <= GAP;
          end
        end

        GAP: begin
          // One idle cycle on the narrow bus, then re-issue the same lane.
          if (!wbs.cyc) begin
            state_q <= IDLE;
          end else begin
            stb_q   <= 1'b1;
            state_q <= ISSUE;
          end
        end

        RESP, FAIL: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Narrow address is the line base with the line offset replaced by the
  // lane offset, so it can never carry into the line-base bits.
  assign wbm.adr   = (adr_q & ~ADDR_WIDTH'((1 << LINE_W) - 1))
                   | ADDR_WIDTH'({lane_q, {LSEL_W{1'b0}}});
  assign wbm.dat_w = dat_q[int'(lane_q)*NARROW_WIDTH +: NARROW_WIDTH];
  assign wbm.sel   = sel_q[int'(lane_q)*LSEL +: LSEL];
  assign wbm.we    = we_q;
  assign wbm.stb   = stb_q;
  assign wbm.cyc   = stb_q;

  assign wbs.dat_r = acc_q;
  assign wbs.ack   = ack_q;
  assign wbs.err   = err_q;
  assign wbs.rty   = 1'b0;

endmodule

// File: tb/tb_wb_downsizer.sv
// -----------------------------------------------------------------------------
// tb_wb_downsizer
//   Self-checking bench for wb_downsizer. A table of wide requests drives the
//   wide side; a narrow-slave responder pops the expected narrow cycles from a
//   scoreboard queue, checks them and answers with the termination recorded
//   for that cycle. Abort and mid-transaction reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_wb_downsizer;
  import wb_downsizer_pkg::*;

  typedef enum int {K_ACK, K_ERR, K_RTY, K_ACK_RTY, K_ERR_ACK} kind_t;

  typedef struct {
    logic         we;
    logic [31:0]  adr;
    logic [15:0]  sel;
    logic [127:0] wdat;
    int           sp_lane;   // lane receiving sp_kind, -1 for none
    kind_t        sp_kind;
    logic         exp_err;
    logic [127:0] exp_dat;   // checked on successful reads only
    int           exp_lat;   // edges from accept to the response cycle
  } vec_t;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
    kind_t       kind;
  } narrow_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  narrow_t exp_q[$];
  vec_t    vecs[10];

  wb_downsizer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) wbs_bus ();
  wb_downsizer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32))  wbm_bus ();

  wb_downsizer dut (
    .clk (clk),
    .rst (rst),
    .wbs (wbs_bus),
    .wbm (wbm_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] rd_data(input logic [31:0] adr);
    return adr ^ 32'h5A00_0000;
  endfunction

  // Narrow slave: zero-wait, answers every strobed cycle seen at negedge.
  initial begin
    narrow_t e;
    wbm_bus.ack   = 1'b0;
    wbm_bus.err   = 1'b0;
    wbm_bus.rty   = 1'b0;
    wbm_bus.dat_r = '0;
    forever begin
      @(negedge clk);
      wbm_bus.ack = 1'b0;
      wbm_bus.err = 1'b0;
      wbm_bus.rty = 1'b0;
      if (wbm_bus.stb === 1'b1) begin
        check("wbm_cyc_eq_stb", wbm_bus.cyc, 1'b1);
        wbm_bus.dat_r = rd_data(wbm_bus.adr);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_narrow: got adr %h sel %h, required no cycle",
                   wbm_bus.adr, wbm_bus.sel);
          wbm_bus.ack = 1'b1;
        end else begin
          e = exp_q.pop_front();
          check("narrow_adr", wbm_bus.adr, e.adr);
          check("narrow_sel", wbm_bus.sel, e.sel);
          check("narrow_we", wbm_bus.we, e.we);
          if (e.we) check("narrow_dat", wbm_bus.dat_w, e.dat);
          wbm_bus.ack = (e.kind == K_ACK) || (e.kind == K_ACK_RTY) || (e.kind == K_ERR_ACK);
          wbm_bus.err = (e.kind == K_ERR) || (e.kind == K_ERR_ACK);
          wbm_bus.rty = (e.kind == K_RTY) || (e.kind == K_ACK_RTY);
        end
      end
    end
  end

  // Reference model of the narrow cycles one wide request should produce.
  task automatic push_expect(input vec_t v);
    narrow_t e;
    for (int l = 0; l < 4; l++) begin
      if (v.sel[l*4 +: 4] != 4'h0) begin
        e.adr  = (v.adr & 32'hFFFF_FFF0) | 32'(l * 4);
        e.sel  = v.sel[l*4 +: 4];
        e.we   = v.we;
        e.dat  = v.wdat[l*32 +: 32];
        e.kind = K_ACK;
        if (l == v.sp_lane) begin
          e.kind = v.sp_kind;
          exp_q.push_back(e);
          if (v.sp_kind == K_RTY) begin
            e.kind = K_ACK;
            exp_q.push_back(e);
          end else if (v.sp_kind == K_ERR || v.sp_kind == K_ERR_ACK) begin
            break;
          end
        end else begin
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic drive_req(input vec_t v);
    wbs_bus.adr   = v.adr;
    wbs_bus.sel   = v.sel;
    wbs_bus.we    = v.we;
    wbs_bus.dat_w = v.wdat;
    wbs_bus.cyc   = 1'b1;
    wbs_bus.stb   = 1'b1;
  endtask

  task automatic idle_req();
    wbs_bus.cyc = 1'b0;
    wbs_bus.stb = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   lat;
    logic got;
    push_expect(v);
    @(negedge clk);
    drive_req(v);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 50) begin
      @(negedge clk);
      lat++;
      if (wbs_bus.ack === 1'b1 || wbs_bus.err === 1'b1) got = 1'b1;
    end
    check($sformatf("v%0d_resp_seen", idx), got, 1'b1);
    check($sformatf("v%0d_err", idx), wbs_bus.err, v.exp_err);
    check($sformatf("v%0d_ack", idx), wbs_bus.ack, !v.exp_err);
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    if (!v.we && !v.exp_err) check($sformatf("v%0d_rdata", idx), wbs_bus.dat_r, v.exp_dat);
    idle_req();
    @(negedge clk);
    check($sformatf("v%0d_ack_pulse", idx), wbs_bus.ack, 1'b0);
    check($sformatf("v%0d_err_pulse", idx), wbs_bus.err, 1'b0);
    check($sformatf("v%0d_narrow_left", idx), exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    vec_t v;

    //          we    adr            sel       wdat                                          sp_lane sp_kind    err   exp_dat                                        lat
    vecs[0] = '{1'b0, 32'h0100_0040, 16'hFFFF, 128'h0,                                       -1,     K_ACK,     1'b0,
                {32'h5B00_004C, 32'h5B00_0048, 32'h5B00_0044, 32'h5B00_0040},                5};
    vecs[1] = '{1'b1, 32'h0100_0080, 16'h0F00, {32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222, 32'h3333_3333},
                -1,   K_ACK,         1'b0,     128'h0,                                       2};
    vecs[2] = '{1'b0, 32'h0100_00C0, 16'h0000, 128'h0,                                       -1,     K_ACK,     1'b0,
                128'h0,                                                                       1};
    vecs[3] = '{1'b0, 32'h0100_0100, 16'hF00F, 128'h0,                                       0,      K_RTY,     1'b0,
                {32'h5B00_010C, 64'h0, 32'h5B00_0100},                                        5};
    vecs[4] = '{1'b0, 32'h0100_0140, 16'hFFFF, 128'h0,                                       1,      K_ERR,     1'b1,
                128'h0,                                                                       3};
    vecs[5] = '{1'b0, 32'h0100_0180, 16'h0060, 128'h0,                                       -1,     K_ACK,     1'b0,
                {64'h0, 32'h5B00_0184, 32'h0},                                                2};
    vecs[6] = '{1'b1, 32'h0100_01C0, 16'hA005, {32'hCAFE_F00D, 32'h4444_4444, 32'h5555_5555, 32'h0BAD_1DEA},
                -1,   K_ACK,         1'b0,     128'h0,                                       3};
    vecs[7] = '{1'b0, 32'h01FF_FFF0, 16'h8000, 128'h0,                                       -1,     K_ACK,     1'b0,
                {32'h5BFF_FFFC, 96'h0},                                                       2};
    vecs[8] = '{1'b0, 32'h0100_0200, 16'h00FF, 128'h0,                                       0,      K_ACK_RTY, 1'b0,
                {64'h0, 32'h5B00_0204, 32'h5B00_0200},                                        3};
    vecs[9] = '{1'b0, 32'h0100_0240, 16'hFFFF, 128'h0,                                       2,      K_ERR_ACK, 1'b1,
                128'h0,                                                                       4};

    // Reset state.
    rst = 1'b1;
    wbs_bus.adr   = '0;
    wbs_bus.dat_w = '0;
    wbs_bus.sel   = '0;
    wbs_bus.we    = 1'b0;
    idle_req();
    repeat (3) @(negedge clk);
    check("rst_wbs_ack", wbs_bus.ack, 1'b0);
    check("rst_wbs_err", wbs_bus.err, 1'b0);
    check("rst_wbs_dat", wbs_bus.dat_r, 128'h0);
    check("rst_wbm_stb", wbm_bus.stb, 1'b0);
    check("rst_wbm_cyc", wbm_bus.cyc, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Abort: wbs_cyc drops while lane 2 is on the narrow bus.
    v = vecs[0];
    v.adr = 32'h0100_0300;
    push_expect(v);
    void'(exp_q.pop_back());           // lane 3 must never be issued
    @(negedge clk);
    drive_req(v);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("abort_no_ack_before", wbs_bus.ack | wbs_bus.err, 1'b0);
    end
    idle_req();                        // lane 2 cycle in progress now
    @(negedge clk);
    check("abort_stb_low", wbm_bus.stb, 1'b0);
    check("abort_cyc_low", wbm_bus.cyc, 1'b0);
    for (int c = 0; c < 3; c++) begin
      check("abort_no_resp", wbs_bus.ack | wbs_bus.err, 1'b0);
      @(negedge clk);
    end
    check("abort_narrow_left", exp_q.size(), 0);
    exp_q.delete();
    run_vec(10, vecs[3]);

    // Reset during lane 1 of a full read.
    v = vecs[0];
    v.adr = 32'h0100_0340;
    push_expect(v);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());           // only lanes 0 and 1 go out
    @(negedge clk);
    drive_req(v);
    repeat (2) @(negedge clk);
    rst = 1'b1;                        // lane 1 cycle in progress now
    idle_req();
    @(negedge clk);
    check("rstmid_stb_low", wbm_bus.stb, 1'b0);
    check("rstmid_cyc_low", wbm_bus.cyc, 1'b0);
    check("rstmid_no_ack", wbs_bus.ack, 1'b0);
    check("rstmid_no_err", wbs_bus.err, 1'b0);
    check("rstmid_dat_clear", wbs_bus.dat_r, 128'h0);
    rst = 1'b0;
    check("rstmid_narrow_left", exp_q.size(), 0);
    exp_q.delete();
    run_vec(11, vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
